// File: rtl/smu_dcu_buf_pkg.sv
// rtl/smu_dcu_buf_pkg.sv - shared queue depth, entry type encoding and entry record
package smu_dcu_buf_pkg;

  localparam int unsigned SMU_Q_DEPTH = 2;
  localparam logic [1:0]  SMU_Q_FULL  = 2'(SMU_Q_DEPTH);

  typedef enum logic {
    ENT_ST = 1'b0,
    ENT_LD = 1'b1
  } ent_type_e;

  typedef struct packed {
    ent_type_e   typ;
    logic        na;
    logic [31:0] addr;
    logic [31:0] data;
  } smu_ent_t;

endpackage

// File: rtl/smu_req_fifo.sv
// rtl/smu_req_fifo.sv - 2-entry in-order request queue with load purge and compaction
module smu_req_fifo
  import smu_dcu_buf_pkg::*;
(
  input  logic       clk,
  input  logic       reset_l,
  input  logic       push,
  input  smu_ent_t   push_ent,
  input  logic       pop,
  input  logic       purge_ld,
  output smu_ent_t   head,
  output logic [1:0] count,
  output logic [1:0] num_ld
);

  smu_ent_t   ent_q [SMU_Q_DEPTH];
  smu_ent_t   ent_d [SMU_Q_DEPTH];
  logic [1:0] count_q, count_d;
  logic       vld0, vld1, keep0, keep1;
  logic [1:0] n_keep;

  // Survivors of pop and purge slide to the front, then the new entry lands behind them.
  always_comb begin
    vld0     = count_q != 2'd0;
    vld1     = count_q == SMU_Q_FULL;
    keep0    = vld0 & ~pop & ~(purge_ld & (ent_q[0].typ == ENT_LD));
    keep1    = vld1 & ~(purge_ld & (ent_q[1].typ == ENT_LD));
    n_keep   = {1'b0, keep0} + {1'b0, keep1};
    ent_d[0] = keep0 ? ent_q[0] : ent_q[1];
    ent_d[1] = ent_q[1];
    if (push) begin
      if (n_keep == 2'd0) begin
        ent_d[0] = push_ent;
      end else begin
        ent_d[1] = push_ent;
      end
    end
    count_d = n_keep + {1'b0, push};
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < SMU_Q_DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
  end

  assign head   = ent_q[0];
  assign count  = count_q;
  assign num_ld = {1'b0, vld0 & (ent_q[0].typ == ENT_LD)}
                + {1'b0, vld1 & (ent_q[1].typ == ENT_LD)};

endmodule

// File: rtl/smu_dcu_buf.sv
// rtl/smu_dcu_buf.sv - dribbler-to-DCU request buffer with load tracking and flush drop
module smu_dcu_buf
  import smu_dcu_buf_pkg::*;
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic        sm,
  input  logic        sin,
  output logic        so,
  input  logic        smu_ld,
  input  logic        smu_st,
  input  logic        smu_na_st,
  input  logic [31:0] smu_addr,
  input  logic [31:0] smu_data,
  input  logic        iu_smu_flush,
  output logic        smu_stall,
  output logic        smu_data_vld,
  output logic [31:0] dcu_data,
  output logic        dcu_req_ld,
  output logic        dcu_req_st,
  output logic        dcu_req_na,
  output logic [31:0] dcu_req_addr,
  output logic [31:0] dcu_req_data,
  input  logic        dcu_ack,
  input  logic        dcu_ld_vld,
  input  logic [31:0] dcu_ld_data
);

  smu_ent_t    push_ent, head;
  logic [1:0]  q_count, q_num_ld;
  logic        q_vld, push, pop, ack_ld, ret_ok;
  logic [2:0]  ld_total;
  logic [1:0]  ld_out_q, ld_out_d, drop_cnt_q, drop_cnt_d;
  logic        data_vld_q, data_vld_d;
  logic [31:0] dcu_data_q, dcu_data_d;
  logic        unused_scan;

  smu_req_fifo u_fifo (
    .clk      (clk),
    .reset_l  (reset_l),
    .push     (push),
    .push_ent (push_ent),
    .pop      (pop),
    .purge_ld (iu_smu_flush),
    .head     (head),
    .count    (q_count),
    .num_ld   (q_num_ld)
  );

  always_comb begin
    push_ent.typ  = smu_ld ? ENT_LD : ENT_ST;
    push_ent.na   = smu_st & smu_na_st;
    push_ent.addr = smu_addr;
    push_ent.data = smu_data;

    q_vld     = q_count != 2'd0;
    ld_total  = {1'b0, ld_out_q} + {1'b0, q_num_ld};
    smu_stall = (q_count == SMU_Q_FULL) | (ld_total >= 3'd2);
    push      = (smu_ld | smu_st) & ~smu_stall & ~(iu_smu_flush & smu_ld);
    pop       = dcu_ack & q_vld;
    ack_ld    = pop & (head.typ == ENT_LD);
    ret_ok    = dcu_ld_vld & (ld_out_q != 2'd0);
    ld_out_d  = ld_out_q + {1'b0, ack_ld} - {1'b0, ret_ok};

    drop_cnt_d = drop_cnt_q;
    data_vld_d = 1'b0;
    dcu_data_d = dcu_data_q;
    // A flush covers every load already issued, including one acked or returning right now.
    if (iu_smu_flush) begin
      drop_cnt_d = ld_out_d;
    end else if (ret_ok) begin
      if (drop_cnt_q != 2'd0) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end else begin
        data_vld_d = 1'b1;
        dcu_data_d = dcu_ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      ld_out_q   <= 2'd0;
      drop_cnt_q <= 2'd0;
      data_vld_q <= 1'b0;
      dcu_data_q <= 32'd0;
    end else begin
      ld_out_q   <= ld_out_d;
      drop_cnt_q <= drop_cnt_d;
      data_vld_q <= data_vld_d;
      dcu_data_q <= dcu_data_d;
    end
  end

  assign so           = 1'b0;
  assign unused_scan  = sm ^ sin;
  assign smu_data_vld = data_vld_q;
  assign dcu_data     = dcu_data_q;
  assign dcu_req_ld   = q_vld & (head.typ == ENT_LD);
  assign dcu_req_st   = q_vld & (head.typ == ENT_ST);
  assign dcu_req_na   = q_vld & (head.typ == ENT_ST) & head.na;
  assign dcu_req_addr = q_vld ? head.addr : 32'd0;
  assign dcu_req_data = q_vld ? head.data : 32'd0;

endmodule

// File: tb/tb_smu_dcu_buf.sv
// tb/tb_smu_dcu_buf.sv - scoreboard bench for smu_dcu_buf against a queue-level model
module tb_smu_dcu_buf;

  logic        clk = 1'b0;
  logic        reset_l = 1'b0;
  logic        sm = 1'b0, sin = 1'b0, so;
  logic        smu_ld = 1'b0, smu_st = 1'b0, smu_na_st = 1'b0;
  logic [31:0] smu_addr = '0, smu_data = '0;
  logic        iu_smu_flush = 1'b0;
  logic        smu_stall, smu_data_vld;
  logic [31:0] dcu_data;
  logic        dcu_req_ld, dcu_req_st, dcu_req_na;
  logic [31:0] dcu_req_addr, dcu_req_data;
  logic        dcu_ack = 1'b0, dcu_ld_vld = 1'b0;
  logic [31:0] dcu_ld_data = '0;

  smu_dcu_buf dut (
    .clk(clk), .reset_l(reset_l), .sm(sm), .sin(sin), .so(so),
    .smu_ld(smu_ld), .smu_st(smu_st), .smu_na_st(smu_na_st),
    .smu_addr(smu_addr), .smu_data(smu_data), .iu_smu_flush(iu_smu_flush),
    .smu_stall(smu_stall), .smu_data_vld(smu_data_vld), .dcu_data(dcu_data),
    .dcu_req_ld(dcu_req_ld), .dcu_req_st(dcu_req_st), .dcu_req_na(dcu_req_na),
    .dcu_req_addr(dcu_req_addr), .dcu_req_data(dcu_req_data),
    .dcu_ack(dcu_ack), .dcu_ld_vld(dcu_ld_vld), .dcu_ld_data(dcu_ld_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          ld;
    bit          na;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;
  typedef struct {
    int          cyc;
    logic [31:0] d;
  } ret_t;

  req_t        mq[$];
  int          m_ld_out = 0;
  int          m_drop = 0;
  logic [66:0] exp_req_q[$];
  ret_t        exp_ret_q[$];

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_lds();
    int n = 0;
    foreach (mq[i]) if (mq[i].ld) n++;
    return n;
  endfunction

  function automatic bit m_stall();
    return (mq.size() == 2) || ((m_ld_out + m_lds()) == 2);
  endfunction

  function automatic logic [66:0] pack_req(input req_t r);
    return {r.ld, !r.ld, !r.ld && r.na, r.addr, r.data};
  endfunction

  // One clock of stimulus; the model advances to the state after the next edge.
  task automatic step(input bit ld, input bit st, input bit na, input logic [31:0] a,
                      input logic [31:0] d, input bit fl, input bit ack, input bit lv,
                      input logic [31:0] ld_d);
    bit acc, ack_ld, ret_ok;
    @(posedge clk);
    #2;
    reset_l = 1'b1;
    chk("smu_stall", 67'(smu_stall), 67'(m_stall()));
    chk("req_present", 67'(dcu_req_ld | dcu_req_st), 67'(mq.size() != 0));
    acc = (ld || st) && !m_stall();
    smu_ld = ld; smu_st = st; smu_na_st = na; smu_addr = a; smu_data = d;
    iu_smu_flush = fl; dcu_ack = ack; dcu_ld_vld = lv; dcu_ld_data = ld_d;
    if (ack) exp_req_q.push_back(mq.size() != 0 ? pack_req(mq[0]) : 67'd0);
    ack_ld = 1'b0;
    if (ack && mq.size() != 0) begin
      ack_ld = mq[0].ld;
      void'(mq.pop_front());
    end
    ret_ok = lv && (m_ld_out > 0);
    if (lv && !ret_ok) $display("note: dcu_ld_vld with no load outstanding (protocol error), ignored");
    if (ret_ok && !fl) begin
      if (m_drop == 0) exp_ret_q.push_back('{cyc + 1, ld_d});
      else m_drop--;
    end
    m_ld_out = m_ld_out + int'(ack_ld) - int'(ret_ok);
    if (fl) begin
      for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].ld) mq.delete(i);
      m_drop = m_ld_out;
    end
    if (acc && !(fl && ld)) mq.push_back('{ld: ld, na: na && st, addr: a, data: d});
  endtask

  task automatic idle(input bit ack, input bit lv, input logic [31:0] ld_d);
    step(0, 0, 0, 32'd0, 32'd0, 0, ack, lv, ld_d);
  endtask

  task automatic rand_step();
    int r;
    r = $urandom_range(0, 9);
    step(r < 3, (r >= 3) && (r < 6), 1'($urandom_range(0, 1)), $urandom, $urandom,
         $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 6,
         (m_ld_out > 0) && ($urandom_range(0, 9) < 4), $urandom);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {smu_stall, smu_data_vld, dcu_data, dcu_req_ld, dcu_req_st, dcu_req_na, so},
        67'd0);
    chk({name, "_req"}, {3'd0, dcu_req_addr, dcu_req_data}, 67'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_l) begin
      if (dcu_ack) begin
        if (exp_req_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dcu_req: ack seen with no expectation queued");
        end else begin
          chk("dcu_req", {dcu_req_ld, dcu_req_st, dcu_req_na, dcu_req_addr, dcu_req_data},
              exp_req_q.pop_front());
        end
      end
      while (exp_ret_q.size() != 0 && exp_ret_q[0].cyc < cyc) begin
        total++; bad++;
        $display("FAIL ret_missing: got none expected %h", exp_ret_q[0].d);
        void'(exp_ret_q.pop_front());
      end
      if (smu_data_vld) begin
        if (exp_ret_q.size() == 0) begin
          total++; bad++;
          $display("FAIL ret_unexpected: got %h expected no smu_data_vld", dcu_data);
        end else begin
          ret_t r;
          r = exp_ret_q.pop_front();
          chk("ret_cycle", 67'(cyc), 67'(r.cyc));
          chk("dcu_data", 67'(dcu_data), 67'(r.d));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk_all_zero("reset_outputs");

    // store then load with ack held, then a return
    step(0, 1, 1, 32'h1000_0010, 32'h5555_0001, 0, 1, 0, 0);
    step(1, 0, 0, 32'h2000_0020, 32'h0, 0, 1, 0, 0);
    idle(1, 0, 0);
    idle(1, 0, 0);
    idle(1, 1, 32'hCAFE_0001);
    idle(0, 0, 0);
    idle(0, 0, 0);

    // three stores with ack low: the third waits for the first ack
    step(0, 1, 0, 32'hA1, 32'h11, 0, 0, 0, 0);
    step(0, 1, 0, 32'hA2, 32'h22, 0, 0, 0, 0);
    step(0, 1, 0, 32'hA3, 32'h33, 0, 0, 0, 0);
    step(0, 1, 0, 32'hA3, 32'h33, 0, 1, 0, 0);
    step(0, 1, 0, 32'hA3, 32'h33, 0, 1, 0, 0);
    repeat (3) idle(1, 0, 0);

    // two loads issued and acked, then flush: both returns dropped
    step(1, 0, 0, 32'hB1, 32'h0, 0, 1, 0, 0);
    step(1, 0, 0, 32'hB2, 32'h0, 0, 1, 0, 0);
    idle(1, 0, 0);
    idle(0, 0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
    idle(0, 1, 32'hDEAD_0001);
    idle(0, 1, 32'hDEAD_0002);
    idle(0, 0, 0);

    // queue {ld A, st B} then flush: st B compacts to the head
    step(1, 0, 0, 32'hC1, 32'h0, 0, 0, 0, 0);
    step(0, 1, 0, 32'hC2, 32'hC2C2, 0, 0, 0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
    idle(1, 0, 0);
    idle(0, 0, 0);

    // flush + ack of head load + return in one cycle
    step(1, 0, 0, 32'hD1, 32'h0, 0, 0, 0, 0);
    step(1, 0, 0, 32'hD2, 32'h0, 0, 0, 0, 0);
    idle(1, 0, 0);
    step(0, 0, 0, 32'h0, 32'h0, 1, 1, 1, 32'hBEEF_0001);
    idle(0, 1, 32'hBEEF_0002);
    idle(0, 0, 0);

    repeat (1500) rand_step();
    repeat (40) idle(1, m_ld_out > 0, $urandom);

    // reset mid-transaction: a load outstanding and a store queued
    step(1, 0, 0, 32'hE1, 32'h0, 0, 0, 0, 0);
    step(0, 1, 0, 32'hE2, 32'hE2E2, 0, 1, 0, 0);
    idle(0, 0, 0);
    @(posedge clk);
    #2;
    smu_ld = 0; smu_st = 0; iu_smu_flush = 0; dcu_ack = 0; dcu_ld_vld = 0;
    reset_l = 1'b0;
    #1;
    chk_all_zero("midreset_outputs");
    mq.delete(); exp_req_q.delete(); exp_ret_q.delete();
    m_ld_out = 0; m_drop = 0;
    repeat (2) @(posedge clk);
    // first push on the first edge after release
    step(0, 1, 0, 32'hF1, 32'hF1F1, 0, 0, 0, 0);
    idle(0, 1, 32'h1234_5678);
    idle(1, 0, 0);
    idle(0, 0, 0);

    repeat (1500) rand_step();
    repeat (40) idle(1, m_ld_out > 0, $urandom);
    idle(0, 0, 0);
    idle(0, 0, 0);

    chk("final_req_sb_empty", 67'(exp_req_q.size()), 67'd0);
    chk("final_ret_sb_empty", 67'(exp_ret_q.size()), 67'd0);
    chk("final_stall", 67'(smu_stall), 67'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/smu_dcu_buf.md
SMU_DCU_BUF -- requirements
Module: smu_dcu_buf

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_l, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have ports sm/sin (input, 1) and so (output, 1): scan hooks; so driven 0.
REQ-004 SHALL have inputs smu_ld, smu_st, smu_na_st (1 each): dribbler fill, spill and non-allocate request strobes.
REQ-005 SHALL have inputs smu_addr (32) and smu_data (32): request address and store data.
REQ-006 SHALL have input iu_smu_flush (1): discard dribbler fills.
REQ-007 SHALL have output smu_stall (1): request not accepted this cycle.
REQ-008 SHALL have outputs smu_data_vld (1) and dcu_data (32): fill data returned to the dribbler.
REQ-009 SHALL have outputs dcu_req_ld, dcu_req_st, dcu_req_na (1 each), dcu_req_addr (32) and dcu_req_data (32): the request to the DCU.
REQ-010 SHALL have input dcu_ack (1): DCU accepts the presented request.
REQ-011 SHALL have inputs dcu_ld_vld (1) and dcu_ld_data (32): in-order load return from the DCU.

Function
REQ-012 SHALL hold a 2-entry in-order request queue. Each entry holds {type ld/st, na, addr[31:0], data[31:0]}.
REQ-013 SHALL push when (smu_ld|smu_st) & ~smu_stall. smu_ld and smu_st are never both asserted. smu_na_st is meaningful only with smu_st.
REQ-014 smu_stall SHALL equal (count==2) | (ld_out + queued_lds == 2), where ld_out is the number of issued loads awaiting return. smu_stall is decoded from registered state only.
REQ-015 SHALL present the head entry on dcu_req_* from the cycle after push; there is no input-to-output bypass.
REQ-016 SHALL hold the dcu_req_* outputs stable until dcu_ack. Pop occurs on the dcu_ack cycle. A load pop increments ld_out.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged. The queue keeps FIFO order.
REQ-018 On dcu_ld_vld with drop_cnt==0, the block SHALL drive smu_data_vld=1 and dcu_data=dcu_ld_data in the next cycle, and decrement ld_out.
REQ-019 On dcu_ld_vld with drop_cnt>0, the block SHALL decrement both drop_cnt and ld_out, and smu_data_vld SHALL stay 0.
REQ-020 On iu_smu_flush, the block SHALL remove every queued load entry. Any remaining store SHALL compact to the head.
REQ-021 On iu_smu_flush, the block SHALL set drop_cnt = ld_out, including a load acked in that same cycle.
REQ-022 A load offered in the flush cycle SHALL be discarded. A store offered in the flush cycle SHALL be accepted.
REQ-023 dcu_ld_vld and flush in the same cycle SHALL drop that return.
REQ-024 ld_out and drop_cnt SHALL be 2-bit counters that never exceed 2. dcu_ld_vld with ld_out==0 is a protocol error: flagged in simulation, with no state change.
REQ-025 Stores SHALL NOT affect ld_out. Stores require no response.

Reset
REQ-026 While reset_l=0, the block SHALL asynchronously clear count, ld_out and drop_cnt.
REQ-027 Reset SHALL drive smu_stall=0, smu_data_vld=0, dcu_data=0, all dcu_req_* =0, and so=0.
REQ-028 Reset mid-transaction SHALL abandon all entries and outstanding loads with no return to the SMU.
REQ-029 Entry address/data storage need not be reset.
REQ-030 The first push SHALL be possible in the first clock edge after reset_l rises.

Structure
REQ-031 A shared package SHALL hold the queue depth (2), the entry type encoding, and the entry record typedef.
REQ-032 The queue SHALL be one sub-module, smu_req_fifo: 2-entry storage with push, pop, and selective load-purge/compaction.
REQ-033 Counters and return logic SHALL reside in smu_dcu_buf.

Verification
REQ-034 Store then load, with dcu_ack held high: dcu_req_st appears 1 cycle after push, followed by dcu_req_ld. dcu_ld_vld returning 0xCAFE0001 gives smu_data_vld with dcu_data=0xCAFE0001 one cycle later.
REQ-035 dcu_ack held 0 and three stores pushed: smu_stall=1 after the second push. The third store is accepted only after the first ack, and order is preserved at the DCU.
REQ-036 Two loads issued and acked, then iu_smu_flush: drop_cnt=2. Both dcu_ld_vld returns yield smu_data_vld=0.
REQ-037 Queue holds {ld A, st B}, then flush: queue holds only st B at the head. dcu_req_st with address B is presented next cycle.
REQ-038 flush, dcu_ack on a head load, and dcu_ld_vld all in one cycle: that return is dropped, drop_cnt=1. The following return is also suppressed.
REQ-039 Assert reset_l=0 with a load outstanding and an entry queued: all outputs are 0 immediately. A later dcu_ld_vld produces no smu_data_vld and is flagged.
